// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment formatter: FSM states, digit map,
// field widths and the time-field saturation value.
package seg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConvA,
    StConvB,
    StCommit
  } state_e;

  localparam int unsigned A_W      = 8;
  localparam int unsigned B_W      = 14;
  localparam int unsigned A_DIGITS = 3;
  localparam int unsigned B_DIGITS = 4;

  localparam int unsigned DIG_MODE   = 7;
  localparam int unsigned FIELD_A_HI = 6;
  localparam int unsigned FIELD_A_LO = 4;
  localparam int unsigned FIELD_B_HI = 3;
  localparam int unsigned FIELD_B_LO = 0;

  localparam logic [7:0] FIELD_A_MASK = 8'b0111_0000;
  localparam logic [7:0] FIELD_B_MASK = 8'b0000_1111;

  localparam logic [B_W-1:0] B_SAT = 14'd9999;

  function automatic logic [B_W-1:0] sat_b(input logic [B_W-1:0] v);
    return (v > B_SAT) ? B_SAT : v;
  endfunction

endpackage

// File: rtl/seg_formatter_if.sv
// Formatter bus: numeric inputs and load strobe from the controller, nibble bus and
// digit enables toward the multiplexed display driver.
interface seg_formatter_if;
  import seg_pkg::*;

  logic                load;
  logic [3:0]          mode;
  logic [A_W-1:0]      val_a;
  logic [B_W-1:0]      val_b;
  logic [1:0]          blink_en;
  logic                busy;
  logic                done;
  logic [31:0]         seg_data;
  logic [7:0]          seg_on;

  modport master (
    output load, mode, val_a, val_b, blink_en,
    input  busy, done, seg_data, seg_on
  );

  modport slave (
    input  load, mode, val_a, val_b, blink_en,
    output busy, done, seg_data, seg_on
  );

endinterface

// File: rtl/bcd_dabble_step.sv
// One shift-add-3 iteration: correct every BCD nibble >= 5 by +3, then shift
// {bcd, bin} left by one so the binary MSB enters the BCD LSB.
module bcd_dabble_step #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic [4*DIGITS-1:0] i_bcd,
  input  logic [BIN_W-1:0]    i_bin,
  output logic [4*DIGITS-1:0] o_bcd,
  output logic [BIN_W-1:0]    o_bin
);

  logic [4*DIGITS-1:0] w_adj;

  always_comb begin
    w_adj = i_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (i_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = i_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign {o_bcd, o_bin} = {w_adj, i_bin} << 1;

endmodule

// File: rtl/seg_formatter.sv
// Formats mode/temperature/time into the display driver's nibble bus and digit mask:
// serial BCD conversion per field, leading-zero blanking and per-field blinking.
module seg_formatter
  import seg_pkg::*;
#(
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_formatter_if.slave bus
);

  localparam int unsigned    CntW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BLINK_HALF - 1);

  state_e                r_state, w_state_nxt;
  logic [3:0]            r_iter, w_iter_nxt;
  logic [3:0]            r_mode;
  logic [A_W-1:0]        r_bin_a, w_bin_a_nxt;
  logic [4*A_DIGITS-1:0] r_bcd_a, w_bcd_a_nxt;
  logic [B_W-1:0]        r_bin_b, w_bin_b_nxt;
  logic [4*B_DIGITS-1:0] r_bcd_b, w_bcd_b_nxt;
  logic [31:0]           r_seg_data;
  logic [7:0]            r_base, w_base;
  logic                  r_done, r_busy;
  logic [CntW-1:0]       r_cnt;
  logic                  r_phase;
  logic [7:0]            r_seg_on, w_hide;

  bcd_dabble_step #(
    .DIGITS (A_DIGITS),
    .BIN_W  (A_W)
  ) u_step_a (
    .i_bcd (r_bcd_a),
    .i_bin (r_bin_a),
    .o_bcd (w_bcd_a_nxt),
    .o_bin (w_bin_a_nxt)
  );

  bcd_dabble_step #(
    .DIGITS (B_DIGITS),
    .BIN_W  (B_W)
  ) u_step_b (
    .i_bcd (r_bcd_b),
    .i_bin (r_bin_b),
    .o_bcd (w_bcd_b_nxt),
    .o_bin (w_bin_b_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_iter  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_iter  <= w_iter_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_iter_nxt  = r_iter;
    case (r_state)
      StIdle: begin
        if (bus.load) begin
          w_state_nxt = StConvA;
          w_iter_nxt  = '0;
        end
      end
      StConvA: begin
        if (r_iter == 4'(A_W - 1)) begin
          w_state_nxt = StConvB;
          w_iter_nxt  = '0;
        end else begin
          w_iter_nxt = r_iter + 4'd1;
        end
      end
      StConvB: begin
        if (r_iter == 4'(B_W - 1)) begin
          w_state_nxt = StCommit;
          w_iter_nxt  = '0;
        end else begin
          w_iter_nxt = r_iter + 4'd1;
        end
      end
      StCommit: w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // A digit is lit once its field value reaches that digit's weight; ones always lit.
  assign w_base = {1'b1,
                   |r_bcd_a[11:8], |r_bcd_a[11:4], 1'b1,
                   |r_bcd_b[15:12], |r_bcd_b[15:8], |r_bcd_b[15:4], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= '0;
      r_bin_a    <= '0;
      r_bcd_a    <= '0;
      r_bin_b    <= '0;
      r_bcd_b    <= '0;
      r_seg_data <= '0;
      r_base     <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_done <= (r_state == StCommit);
      // Registered one cycle behind the FSM so it drops together with the done pulse.
      r_busy <= (r_state == StConvA) || (r_state == StConvB);
      case (r_state)
        StIdle: begin
          if (bus.load) begin
            r_mode  <= bus.mode;
            r_bin_a <= bus.val_a;
            r_bin_b <= sat_b(bus.val_b);
            r_bcd_a <= '0;
            r_bcd_b <= '0;
          end
        end
        StConvA: begin
          r_bcd_a <= w_bcd_a_nxt;
          r_bin_a <= w_bin_a_nxt;
        end
        StConvB: begin
          r_bcd_b <= w_bcd_b_nxt;
          r_bin_b <= w_bin_b_nxt;
        end
        StCommit: begin
          r_seg_data <= {r_mode, r_bcd_a, r_bcd_b};
          r_base     <= w_base;
        end
        default: ;
      endcase
    end
  end

  assign w_hide = ((bus.blink_en[0] && !r_phase) ? FIELD_A_MASK : 8'h00) |
                  ((bus.blink_en[1] && !r_phase) ? FIELD_B_MASK : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_phase  <= 1'b1;
      r_seg_on <= '0;
    end else begin
      if (r_cnt == CntMax) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_seg_on <= r_base & ~w_hide;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.seg_data = r_seg_data;
  assign bus.seg_on   = r_seg_on;

endmodule

// File: tb/tb_seg_formatter.sv
// Directed bench for seg_formatter: decimal-arithmetic reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_seg_formatter;

  localparam int BH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seg_formatter_if bus ();

  seg_formatter #(
    .BLINK_HALF (BH)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: expected outputs derived from decimal digits and edge counts.
  function automatic logic [31:0] fmt_data(input logic [3:0] m, input int a, input int b);
    int bs;
    bs = (b > 9999) ? 9999 : b;
    return {m, 4'(a / 100), 4'((a / 10) % 10), 4'(a % 10),
            4'(bs / 1000), 4'((bs / 100) % 10), 4'((bs / 10) % 10), 4'(bs % 10)};
  endfunction

  function automatic logic [7:0] fmt_mask(input int a, input int b);
    int bs;
    bs = (b > 9999) ? 9999 : b;
    return {1'b1, a >= 100, a >= 10, 1'b1, bs >= 1000, bs >= 100, bs >= 10, 1'b1};
  endfunction

  function automatic logic [7:0] hide_mask(input logic [1:0] en, input bit vis);
    return {1'b0, {3{en[0] && !vis}}, {4{en[1] && !vis}}};
  endfunction

  int          m_cnt     = 0;
  int          m_cyc     = 0;
  logic        exp_busy  = 1'b0;
  logic        exp_done  = 1'b0;
  logic [31:0] exp_data  = '0;
  logic [7:0]  exp_base  = '0;
  logic [7:0]  exp_on    = '0;
  logic [31:0] pend_data = '0;
  logic [7:0]  pend_base = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt    <= 0;
      m_cyc    <= 0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_data <= '0;
      exp_base <= '0;
      exp_on   <= '0;
    end else begin
      m_cyc    <= m_cyc + 1;
      exp_on   <= exp_base & ~hide_mask(bus.blink_en, ((m_cyc / BH) % 2) == 0);
      exp_done <= (m_cnt == 23);
      exp_busy <= (m_cnt >= 1) && (m_cnt <= 22);
      if (m_cnt == 0) begin
        if (bus.load) begin
          m_cnt     <= 1;
          pend_data <= fmt_data(bus.mode, int'(bus.val_a), int'(bus.val_b));
          pend_base <= fmt_mask(int'(bus.val_a), int'(bus.val_b));
        end
      end else if (m_cnt == 23) begin
        m_cnt    <= 0;
        exp_data <= pend_data;
        exp_base <= pend_base;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    chk("done", 32'(bus.done), 32'(exp_done));
    chk("seg_data", bus.seg_data, exp_data);
    chk("seg_on", 32'(bus.seg_on), 32'(exp_on));
  end

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after a negedge; returns just after the edge that samples load.
  task automatic start_load(input logic [3:0] m, input logic [7:0] a, input logic [13:0] b);
    bus.mode  = m;
    bus.val_a = a;
    bus.val_b = b;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    bus.mode  = ~m;
    bus.val_a = ~a;
    bus.val_b = 14'($urandom_range(0, 16383));
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    int n_ff, n_8f, n_bsteady;
    bus.load     = 1'b0;
    bus.mode     = '0;
    bus.val_a    = '0;
    bus.val_b    = '0;
    bus.blink_en = 2'b00;
    clocks(3);
    chk("rst_seg_data", bus.seg_data, 32'h0);
    chk("rst_seg_on", 32'(bus.seg_on), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    clocks(1);

    start_load(4'hA, 8'd45, 14'd1234);
    clocks(1);
    chk("t1_busy_n1", 32'(bus.busy), 32'h1);
    wait_done(ok);
    chk("t1_done_seen", 32'(ok), 32'h1);
    chk("t1_seg_data", bus.seg_data, 32'hA045_1234);
    clocks(1);
    chk("t1_seg_on", 32'(bus.seg_on), 32'(8'b1011_1111));

    start_load(4'h0, 8'd0, 14'd7);
    wait_done(ok);
    chk("t2_done_seen", 32'(ok), 32'h1);
    chk("t2_seg_data", bus.seg_data, 32'h0000_0007);
    clocks(1);
    chk("t2_seg_on", 32'(bus.seg_on), 32'(8'b1001_0001));

    start_load(4'h3, 8'd255, 14'd12000);
    wait_done(ok);
    chk("t3_done_seen", 32'(ok), 32'h1);
    chk("t3_field_b", 32'(bus.seg_data[15:0]), 32'h9999);
    chk("t3_field_a", 32'(bus.seg_data[27:16]), 32'h255);
    clocks(1);
    chk("t3_seg_on", 32'(bus.seg_on), 32'hFF);

    bus.blink_en = 2'b01;
    n_ff = 0;
    n_8f = 0;
    n_bsteady = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.seg_on === 8'hFF) n_ff++;
      if (bus.seg_on === 8'h8F) n_8f++;
      if (bus.seg_on[3:0] === 4'hF) n_bsteady++;
    end
    chk("blink_ff_count", 32'(n_ff), 32'd8);
    chk("blink_8f_count", 32'(n_8f), 32'd8);
    chk("blink_b_steady", 32'(n_bsteady), 32'd16);
    bus.blink_en = 2'b00;
    clocks(2);

    start_load(4'h6, 8'd7, 14'd80);
    clocks(4);
    bus.load = 1'b1;
    clocks(1);
    bus.load = 1'b0;
    clocks(17);
    bus.load = 1'b1;
    clocks(1);
    bus.load = 1'b0;
    chk("t4_done_n23", 32'(bus.done), 32'h1);
    chk("t4_seg_data", bus.seg_data, 32'h6007_0080);
    clocks(1);
    chk("t4_done_once", 32'(bus.done), 32'h0);
    chk("t4_idle", 32'(bus.busy), 32'h0);
    chk("t4_seg_on", 32'(bus.seg_on), 32'h93);
    clocks(30);
    chk("t4_no_restart", 32'(bus.seg_data), 32'h6007_0080);

    start_load(4'h9, 8'd123, 14'd4567);
    clocks(9);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(bus.busy), 32'h0);
    chk("t6_rst_seg_on", 32'(bus.seg_on), 32'h0);
    chk("t6_rst_seg_data", bus.seg_data, 32'h0);
    clocks(2);
    rst_n = 1'b1;
    clocks(1);
    start_load(4'h5, 8'd100, 14'd9);
    wait_done(ok);
    chk("t6_done_seen", 32'(ok), 32'h1);
    chk("t6_seg_data", bus.seg_data, 32'h5100_0009);
    clocks(1);
    chk("t6_seg_on", 32'(bus.seg_on), 32'hF1);
    clocks(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
